prog_loader: RTL and testbench



---
 rtl/prog_loader.sv | 195 +++++++++++++++++++
 tb/tb_prog_loader.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program loader and run controller: packs a byte stream into 9-bit instructions,
// writes them into instruction memory from address 0, then sequences START/DONE runs.
module prog_loader #(
    parameter int ADDR_W       = 10,
    parameter int DEPTH        = 1024,
    parameter int START_CYCLES = 2,
    parameter int MAX_RUN      = 65535
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              go,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [8:0]        imem_wdata,
    output logic              START,
    input  logic              DONE,
    output logic              busy,
    output logic              finished,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   instr_count,
    output logic [15:0]       run_cycles
);

    // state      | meaning
    // LOAD_LO    | waiting for low byte of next instruction
    // LOAD_HI    | waiting for high byte (bit 0 -> instr[8]), then write
    // ARMED      | program loaded, waiting for go
    // START_P    | START held high for START_CYCLES cycles
    // RUN        | counting cycles until DONE or timeout
    // FINISHED   | run complete, go reruns without reload
    // ERROR      | sticky error, only reset leaves
    typedef enum logic [2:0] {
        S_LOAD_LO,
        S_LOAD_HI,
        S_ARMED,
        S_START_P,
        S_RUN,
        S_FINISHED,
        S_ERROR
    } state_t;

    localparam logic [ADDR_W:0] LAST_ADDR  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_ONE    = (ADDR_W+1)'(1);
    localparam logic [15:0]     START_LOAD = 16'(START_CYCLES - 1);
    localparam logic [15:0]     RUN_LIMIT  = 16'(MAX_RUN);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ODD     = 2'b01;
    localparam logic [1:0] ERR_OVF     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    state_t              state_q, state_d;
    logic [7:0]          lo_q, lo_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [8:0]          wdata_q, wdata_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [15:0]         run_q, run_d;
    logic [15:0]         start_cnt_q, start_cnt_d;
    logic [1:0]          err_q, err_d;
    logic [15:0]         run_inc;
    logic                hs;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= S_LOAD_LO;
            lo_q        <= 8'd0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= 9'd0;
            cnt_q       <= '0;
            run_q       <= 16'd0;
            start_cnt_q <= 16'd0;
            err_q       <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            run_q       <= run_d;
            start_cnt_q <= start_cnt_d;
            err_q       <= err_d;
        end
    end

    assign hs      = in_valid & in_ready;
    assign run_inc = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        run_d       = run_q;
        start_cnt_d = start_cnt_q;
        err_d       = err_q;
        case (state_q)
            S_LOAD_LO: begin
                if (hs) begin
                    lo_d = in_data;
                    if (in_last) begin
                        state_d = S_ERROR;
                        err_d   = ERR_ODD;
                    end else begin
                        state_d = S_LOAD_HI;
                    end
                end
            end
            S_LOAD_HI: begin
                if (hs) begin
                    we_d    = 1'b1;
                    waddr_d = cnt_q[ADDR_W-1:0];
                    wdata_d = {in_data[0], lo_q};
                    cnt_d   = cnt_q + CNT_ONE;
                    if (in_last) begin
                        state_d = S_ARMED;
                    end else if (cnt_q == LAST_ADDR) begin
                        // the final slot is still written before flagging overflow
                        state_d = S_ERROR;
                        err_d   = ERR_OVF;
                    end else begin
                        state_d = S_LOAD_LO;
                    end
                end
            end
            S_ARMED, S_FINISHED: begin
                if (go) begin
                    run_d       = 16'd0;
                    start_cnt_d = START_LOAD;
                    state_d     = S_START_P;
                end
            end
            S_START_P: begin
                if (start_cnt_q == 16'd0) begin
                    state_d = S_RUN;
                end else begin
                    start_cnt_d = start_cnt_q - 16'd1;
                end
            end
            S_RUN: begin
                if (DONE) begin
                    state_d = S_FINISHED;
                end else begin
                    run_d = run_inc;
                    if (run_inc >= RUN_LIMIT) begin
                        state_d = S_ERROR;
                        err_d   = ERR_TIMEOUT;
                    end
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_LOAD_LO;
            end
        endcase
    end

    // handshake-facing outputs decode registered state only
    always_comb begin
        in_ready = 1'b0;
        START    = 1'b0;
        busy     = 1'b0;
        finished = 1'b0;
        case (state_q)
            S_LOAD_LO, S_LOAD_HI: in_ready = 1'b1;
            S_START_P: begin
                START = 1'b1;
                busy  = 1'b1;
            end
            S_RUN:      busy     = 1'b1;
            S_FINISHED: finished = 1'b1;
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign imem_we     = we_q;
    assign imem_waddr  = waddr_q;
    assign imem_wdata  = wdata_q;
    assign err_code    = err_q;
    assign instr_count = cnt_q;
    assign run_cycles  = run_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: write scoreboard fed by a byte-level model, plus
// per-scenario tasks for run sequencing, errors and reset behaviour.
module tb_prog_loader;

    localparam int ADDR_W       = 10;
    localparam int DEPTH        = 4;
    localparam int START_CYCLES = 2;
    localparam int MAX_RUN      = 20;
    localparam logic [52:0] RST_VEC = {1'b1, 52'd0};

    logic              CLK = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              in_ready;
    logic              go;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [8:0]        imem_wdata;
    logic              START;
    logic              DONE;
    logic              busy;
    logic              finished;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   instr_count;
    logic [15:0]       run_cycles;

    prog_loader #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .START_CYCLES(START_CYCLES), .MAX_RUN(MAX_RUN)
    ) dut (
        .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .go(go), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .START(START),
        .DONE(DONE), .busy(busy), .finished(finished), .err_code(err_code),
        .instr_count(instr_count), .run_cycles(run_cycles)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [8:0]        d;
        int                c;
    } wr_t;
    wr_t exp_q[$];

    logic [7:0] lo_m;
    bit         hi_m;
    int         cnt_m;

    always @(negedge CLK) begin
        wr_t e;
        if (imem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h cyc=%0d, required no write",
                         imem_waddr, imem_wdata, cyc);
            end else begin
                e = exp_q.pop_front();
                if (imem_waddr !== e.a || imem_wdata !== e.d || cyc != e.c) begin
                    failures++;
                    $display("FAIL write: got addr=%0h data=%0h cyc=%0d, required addr=%0h data=%0h cyc=%0d",
                             imem_waddr, imem_wdata, cyc, e.a, e.d, e.c);
                end
            end
        end
    end

    function automatic logic [52:0] outs();
        return {in_ready, imem_we, imem_waddr, imem_wdata, START, busy, finished,
                err_code, instr_count, run_cycles};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        hi_m  = 1'b0;
        cnt_m = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_clear();
    endtask

    task automatic pulse_go();
        go = 1'b1;
        step();
        go = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic last, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (in_ready === 1'b1) begin
                if (hi_m) begin
                    exp_q.push_back('{a: ADDR_W'(cnt_m), d: {b[0], lo_m}, c: cyc + 1});
                    cnt_m++;
                end else begin
                    lo_m = b;
                end
                hi_m = !hi_m;
                ok   = 1'b1;
            end
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic drain(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d writes still outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic load_prog3(input int max_gap);
        logic [7:0] bytes [6];
        bit ok;
        bytes = '{8'hA5, 8'h01, 8'h3C, 8'h00, 8'hFF, 8'h01};
        for (int k = 0; k < 6; k++) begin
            for (int g = $urandom_range(0, max_gap); g > 0; g--) begin
                in_data = 8'($urandom);
                step();
            end
            send(bytes[k], k == 5, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL load_accept: byte %0d not accepted, required accepted", k);
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        step();
        checks += 7;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
        if (imem_we !== 1'b0 || imem_waddr !== '0 || imem_wdata !== 9'd0) begin
            failures++; $display("FAIL rst_imem: got we=%b a=%0h d=%0h, required 0/0/0", imem_we, imem_waddr, imem_wdata);
        end
        if (START !== 1'b0) begin failures++; $display("FAIL rst_start: got %b, required 0", START); end
        if (busy !== 1'b0 || finished !== 1'b0) begin
            failures++; $display("FAIL rst_status: got busy=%b finished=%b, required 0/0", busy, finished);
        end
        if (err_code !== 2'b00) begin failures++; $display("FAIL rst_err: got %b, required 00", err_code); end
        if (instr_count !== '0) begin failures++; $display("FAIL rst_count: got %0d, required 0", instr_count); end
        if (run_cycles !== 16'd0) begin failures++; $display("FAIL rst_run: got %0d, required 0", run_cycles); end
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_load3();
        int t0;
        t0 = cyc;
        load_prog3(0);
        checks++;
        if (cyc - t0 != 6) begin
            failures++; $display("FAIL throughput: 6 bytes took %0d cycles, required 6", cyc - t0);
        end
        step(); step();
        drain("load3");
        checks++;
        if (instr_count !== 11'd3 || in_ready !== 1'b0 || busy !== 1'b0 || finished !== 1'b0 || err_code !== 2'b00) begin
            failures++;
            $display("FAIL load3_armed: got cnt=%0d rdy=%b busy=%b fin=%b err=%b, required 3/0/0/0/00",
                     instr_count, in_ready, busy, finished, err_code);
        end
    endtask

    task automatic test_run();
        int start_hi;
        start_hi = 0;
        pulse_go();
        for (int i = 0; i < 14; i++) begin
            start_hi += (START === 1'b1) ? 1 : 0;
            if (i == 0) begin
                checks++;
                if (busy !== 1'b1) begin failures++; $display("FAIL run_busy: got %b, required 1", busy); end
            end
            if (i == 2) begin
                checks++;
                if (START !== 1'b0 || busy !== 1'b1) begin
                    failures++; $display("FAIL run_enter: got START=%b busy=%b, required 0/1", START, busy);
                end
            end
            if (i == 12) begin
                checks++;
                if (run_cycles !== 16'd10) begin failures++; $display("FAIL run_count: got %0d, required 10", run_cycles); end
            end
            DONE = (i == 0 || i == 12);
            go   = (i == 5);
            step();
        end
        DONE = 1'b0;
        go   = 1'b0;
        checks += 2;
        if (start_hi != 2) begin failures++; $display("FAIL run_start_len: got %0d cycles, required 2", start_hi); end
        if (finished !== 1'b1 || busy !== 1'b0 || run_cycles !== 16'd10) begin
            failures++; $display("FAIL run_finish: got fin=%b busy=%b run=%0d, required 1/0/10", finished, busy, run_cycles);
        end
        step(); step(); step();
        checks++;
        if (finished !== 1'b1 || run_cycles !== 16'd10) begin
            failures++; $display("FAIL run_freeze: got fin=%b run=%0d, required 1/10", finished, run_cycles);
        end
        start_hi = 0;
        pulse_go();
        for (int i = 0; i < 10; i++) begin
            start_hi += (START === 1'b1) ? 1 : 0;
            if (i == 1) begin
                checks++;
                if (run_cycles !== 16'd0) begin failures++; $display("FAIL rerun_clear: got %0d, required 0", run_cycles); end
            end
            DONE = (i == 7);
            step();
        end
        DONE = 1'b0;
        checks++;
        if (start_hi != 2 || finished !== 1'b1 || run_cycles !== 16'd5) begin
            failures++;
            $display("FAIL rerun: got start=%0d fin=%b run=%0d, required 2/1/5", start_hi, finished, run_cycles);
        end
    endtask

    task automatic test_odd();
        bit ok;
        do_reset();
        send(8'hA5, 1'b1, ok);
        checks++;
        if (!ok || err_code !== 2'b01 || in_ready !== 1'b0 || instr_count !== '0) begin
            failures++;
            $display("FAIL odd: got ok=%b err=%b rdy=%b cnt=%0d, required 1/01/0/0", ok, err_code, in_ready, instr_count);
        end
        pulse_go();
        checks++;
        if (START !== 1'b0 || busy !== 1'b0 || err_code !== 2'b01) begin
            failures++; $display("FAIL odd_go: got START=%b busy=%b err=%b, required 0/0/01", START, busy, err_code);
        end
        step();
        drain("odd");
    endtask

    task automatic test_overflow();
        bit ok;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            send(8'(8'h10 + k), 1'b0, ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL ovf_accept: byte %0d not accepted, required accepted", k); end
        end
        checks++;
        if (err_code !== 2'b10 || in_ready !== 1'b0 || instr_count !== 11'd4) begin
            failures++; $display("FAIL ovf: got err=%b rdy=%b cnt=%0d, required 10/0/4", err_code, in_ready, instr_count);
        end
        send(8'h55, 1'b0, ok);
        checks++;
        if (ok) begin failures++; $display("FAIL ovf_reject: got accepted, required not accepted"); end
        drain("ovf");
    endtask

    task automatic test_timeout();
        bit ok;
        int at;
        do_reset();
        send(8'h12, 1'b0, ok);
        send(8'h01, 1'b1, ok);
        step();
        DONE = 1'b0;
        pulse_go();
        at = -1;
        for (int i = 0; i < 40 && at < 0; i++) begin
            if (err_code !== 2'b00) at = i;
            else step();
        end
        checks++;
        if (at != 22 || err_code !== 2'b11 || run_cycles !== 16'd20 || START !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout: got at=%0d err=%b run=%0d START=%b busy=%b, required 22/11/20/0/0",
                     at, err_code, run_cycles, START, busy);
        end
        pulse_go();
        checks++;
        if (START !== 1'b0 || err_code !== 2'b11) begin
            failures++; $display("FAIL timeout_go: got START=%b err=%b, required 0/11", START, err_code);
        end
        drain("timeout");
    endtask

    task automatic test_mid_reset();
        bit ok;
        for (int scen = 0; scen < 3; scen++) begin
            do_reset();
            send(8'h21, 1'b0, ok);
            send(8'h01, scen != 0, ok);
            send(8'h33, 1'b0, ok);
            if (scen != 0) begin
                step();
                pulse_go();
                if (scen == 2) begin step(); step(); step(); end
            end
            in_valid = 1'b1;
            in_data  = 8'h77;
            reset    = 1'b1;
            step();
            checks++;
            if (outs() !== RST_VEC) begin
                failures++; $display("FAIL mid_reset_%0d: got %h, required %h", scen, outs(), RST_VEC);
            end
            reset    = 1'b0;
            in_valid = 1'b0;
            model_clear();
            step();
        end
    endtask

    task automatic test_random_gaps();
        do_reset();
        load_prog3(3);
        step(); step();
        drain("gaps");
        checks++;
        if (instr_count !== 11'd3 || in_ready !== 1'b0) begin
            failures++; $display("FAIL gaps_armed: got cnt=%0d rdy=%b, required 3/0", instr_count, in_ready);
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        in_last  = 1'b0;
        go       = 1'b0;
        DONE     = 1'b0;
        model_clear();
        test_reset();
        test_load3();
        test_run();
        test_odd();
        test_overflow();
        test_timeout();
        test_mid_reset();
        test_random_gaps();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
